// File: rtl/pipe_in_check_wide.sv
// Pipe In word checker: compares each WIDTH-bit word against a generated pattern
// and models a throttled virtual FIFO that drives pipe_in_ready.
module pipe_in_check_wide #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 65536,
   parameter int BLOCK = 1024
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             pipe_in_write,
   input  logic [WIDTH-1:0] pipe_in_data,
   output logic             pipe_in_ready,
   input  logic             throttle_set,
   input  logic [31:0]      throttle_val,
   input  logic [31:0]      fixed_pattern,
   input  logic [1:0]       pattern,
   input  logic             clear_stats,
   output logic [31:0]      error_count,
   output logic [31:0]      word_count,
   output logic             overflow,
   output logic             first_err_valid,
   output logic [31:0]      first_err_index,
   output logic [WIDTH-1:0] first_err_expected,
   output logic [WIDTH-1:0] first_err_received
);

   localparam int LANES = WIDTH / 32;
   localparam int LW    = $clog2(DEPTH + 1);
   localparam logic [LW-1:0] LEVEL_MAX   = LW'(DEPTH);
   localparam logic [LW-1:0] READY_LIMIT = LW'(DEPTH - BLOCK);

   function automatic logic [31:0] xorshift32(input logic [31:0] x);
      logic [31:0] y;
      y = x ^ (x << 5'd13);
      y = y ^ (y >> 5'd17);
      y = y ^ (y << 5'd5);
      return y;
   endfunction

   logic [LW-1:0]    level_r;
   logic [31:0]      throttle_r;
   logic [31:0]      gen_count_r;
   logic [31:0]      gen_walk_r;
   logic [31:0]      gen_lfsr_r;
   logic [WIDTH-1:0] expected_s;
   logic             mismatch_s;
   logic             drain_s;
   logic [LW-1:0]    level_next_s;
   logic             overflow_hit_s;
   logic [31:0]      seed_s;

   assign drain_s    = throttle_r[0];
   assign mismatch_s = pipe_in_write && (pipe_in_data != expected_s);
   assign seed_s     = (fixed_pattern == 32'd0) ? 32'd1 : fixed_pattern;

   // Expected word for the current generator state, built lane by lane.
   always_comb begin
      expected_s = '0;
      for (int i = 0; i < LANES; i++) begin
         case (pattern)
            2'd0:    expected_s[32*i +: 32] = fixed_pattern;
            2'd1:    expected_s[32*i +: 32] = gen_count_r + 32'(i);
            2'd2:    expected_s[32*i +: 32] = gen_walk_r;
            2'd3:    expected_s[32*i +: 32] = gen_lfsr_r;
            default: expected_s[32*i +: 32] = fixed_pattern;
         endcase
      end
   end

   // Virtual FIFO level update; a simultaneous write and drain cancel out.
   always_comb begin
      level_next_s   = level_r;
      overflow_hit_s = 1'b0;
      if (pipe_in_write && !drain_s) begin
         if (level_r < LEVEL_MAX) begin
            level_next_s = level_r + LW'(1);
         end else begin
            overflow_hit_s = 1'b1;
         end
      end else if (!pipe_in_write && drain_s) begin
         if (level_r != LW'(0)) begin
            level_next_s = level_r - LW'(1);
         end else begin
            level_next_s = level_r;
         end
      end else begin
         level_next_s = level_r;
      end
   end

   // FIFO level, throttle mask, ready flag and pattern generators.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         level_r       <= '0;
         throttle_r    <= throttle_val;
         pipe_in_ready <= 1'b0;
         gen_count_r   <= 32'd0;
         gen_walk_r    <= 32'd1;
         gen_lfsr_r    <= seed_s;
      end else begin
         level_r       <= level_next_s;
         throttle_r    <= throttle_set ? throttle_val : {throttle_r[0], throttle_r[31:1]};
         pipe_in_ready <= (level_r < READY_LIMIT);
         if (pipe_in_write) begin
            gen_count_r <= gen_count_r + 32'(LANES);
            gen_walk_r  <= {gen_walk_r[30:0], gen_walk_r[31]};
            gen_lfsr_r  <= xorshift32(gen_lfsr_r);
         end
      end
   end

   // Statistics; clear_stats takes priority over a write in the same cycle.
   always_ff @(posedge clk) begin
      if (!reset_n || clear_stats) begin
         error_count        <= 32'd0;
         word_count         <= 32'd0;
         overflow           <= 1'b0;
         first_err_valid    <= 1'b0;
         first_err_index    <= 32'd0;
         first_err_expected <= '0;
         first_err_received <= '0;
      end else if (pipe_in_write) begin
         word_count <= word_count + 32'd1;
         if (overflow_hit_s) begin
            overflow <= 1'b1;
         end
         if (mismatch_s) begin
            if (error_count != 32'hFFFF_FFFF) begin
               error_count <= error_count + 32'd1;
            end
            if (!first_err_valid) begin
               first_err_valid    <= 1'b1;
               first_err_index    <= word_count;
               first_err_expected <= expected_s;
               first_err_received <= pipe_in_data;
            end
         end
      end
   end

endmodule

// File: tb/tb_pipe_in_check_wide.sv
// Randomised and directed bench for pipe_in_check_wide, checked every cycle
// against a behavioural model of the checker and its virtual FIFO.
module tb_pipe_in_check_wide;

   localparam int W     = 128;
   localparam int LANES = W / 32;
   localparam int DEPTH = 1024;
   localparam int BLOCK = 256;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          pipe_in_write = 1'b0;
   logic [W-1:0]  pipe_in_data = '0;
   logic          pipe_in_ready;
   logic          throttle_set = 1'b0;
   logic [31:0]   throttle_val = 32'd0;
   logic [31:0]   fixed_pattern = 32'd0;
   logic [1:0]    pattern = 2'd0;
   logic          clear_stats = 1'b0;
   logic [31:0]   error_count;
   logic [31:0]   word_count;
   logic          overflow;
   logic          first_err_valid;
   logic [31:0]   first_err_index;
   logic [W-1:0]  first_err_expected;
   logic [W-1:0]  first_err_received;

   pipe_in_check_wide #(.WIDTH(W), .DEPTH(DEPTH), .BLOCK(BLOCK)) dut (
      .clk(clk), .reset_n(reset_n), .pipe_in_write(pipe_in_write),
      .pipe_in_data(pipe_in_data), .pipe_in_ready(pipe_in_ready),
      .throttle_set(throttle_set), .throttle_val(throttle_val),
      .fixed_pattern(fixed_pattern), .pattern(pattern), .clear_stats(clear_stats),
      .error_count(error_count), .word_count(word_count), .overflow(overflow),
      .first_err_valid(first_err_valid), .first_err_index(first_err_index),
      .first_err_expected(first_err_expected), .first_err_received(first_err_received)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0]  level;
      logic [31:0]  thr;
      logic [31:0]  adv;
      logic [31:0]  lfsr;
      logic         ready;
      logic [31:0]  errs;
      logic [31:0]  words;
      logic         ovf;
      logic         fev;
      logic [31:0]  fidx;
      logic [W-1:0] fexp;
      logic [W-1:0] frcv;
   } model_t;

   model_t m;
   int     checks = 0;
   int     errors = 0;
   bit     chk_en = 1'b0;
   bit     preset_err = 1'b0;

   function automatic logic [31:0] xs(input logic [31:0] x);
      logic [31:0] y;
      y = x ^ (x << 13);
      y = y ^ (y >> 17);
      y = y ^ (y << 5);
      return y;
   endfunction

   // Expected word from the number of generator advances since reset.
   function automatic logic [W-1:0] exp_word(input model_t s, input logic [1:0] p, input logic [31:0] fp);
      logic [W-1:0] e;
      e = '0;
      for (int i = 0; i < LANES; i++) begin
         case (p)
            2'd0:    e[32*i +: 32] = fp;
            2'd1:    e[32*i +: 32] = 32'(s.adv * 32'(LANES) + 32'(i));
            2'd2:    e[32*i +: 32] = 32'd1 << (s.adv % 32);
            default: e[32*i +: 32] = s.lfsr;
         endcase
      end
      return e;
   endfunction

   function automatic model_t step(input model_t s, input logic rn, input logic w,
                                   input logic [W-1:0] d, input logic ts, input logic [31:0] tv,
                                   input logic [31:0] fp, input logic [1:0] p, input logic cs,
                                   input logic preset);
      model_t n;
      logic [W-1:0] e;
      n = s;
      if (!rn) begin
         n = '0;
         n.thr  = tv;
         n.lfsr = (fp == 32'd0) ? 32'd1 : fp;
         return n;
      end
      e = exp_word(s, p, fp);
      n.thr   = ts ? tv : ((s.thr >> 1) | (s.thr << 31));
      n.ready = (s.level < DEPTH - BLOCK);
      if (w && !s.thr[0]) begin
         if (s.level < DEPTH) n.level = s.level + 1;
         else n.ovf = 1'b1;
      end else if (!w && s.thr[0] && s.level > 0) begin
         n.level = s.level - 1;
      end
      if (w) begin
         n.adv  = s.adv + 1;
         n.lfsr = xs(s.lfsr);
      end
      if (preset) n.errs = 32'hFFFF_FFFD;
      if (cs) begin
         n.errs = 0; n.words = 0; n.ovf = 0; n.fev = 0; n.fidx = 0; n.fexp = '0; n.frcv = '0;
      end else if (w) begin
         n.words = s.words + 1;
         if (d != e) begin
            if (n.errs != 32'hFFFF_FFFF) n.errs = n.errs + 1;
            if (!s.fev) begin
               n.fev = 1'b1; n.fidx = s.words; n.fexp = e; n.frcv = d;
            end
         end
      end
      return n;
   endfunction

   always @(posedge clk)
      m <= step(m, reset_n, pipe_in_write, pipe_in_data, throttle_set, throttle_val,
                fixed_pattern, pattern, clear_stats, preset_err);

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input bit bad);
      logic [W-1:0] d;
      d = exp_word(m, pattern, fixed_pattern);
      if (bad) d = d ^ ({{(W-1){1'b0}}, 1'b1} << $urandom_range(0, W-1));
      pipe_in_write = 1'b1;
      pipe_in_data  = d;
      tick();
      pipe_in_write = 1'b0;
   endtask

   task automatic do_reset(input logic [31:0] tv, input logic [31:0] fp, input logic [1:0] p);
      throttle_val = tv; fixed_pattern = fp; pattern = p;
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
   endtask

   initial begin
      logic [W-1:0] word_v;
      logic [W-1:0] exp_v;
      int first_low;

      fork
         forever begin
            @(negedge clk);
            if (chk_en && !preset_err) begin
               chk("ready", W'(pipe_in_ready), W'(m.ready));
               chk("error_count", W'(error_count), W'(m.errs));
               chk("word_count", W'(word_count), W'(m.words));
               chk("overflow", W'(overflow), W'(m.ovf));
               chk("first_err_valid", W'(first_err_valid), W'(m.fev));
               chk("first_err_index", W'(first_err_index), W'(m.fidx));
               chk("first_err_expected", first_err_expected, m.fexp);
               chk("first_err_received", first_err_received, m.frcv);
            end
         end
      join_none

      // Counting pattern, four correct words driven as literals.
      do_reset(32'd0, 32'd0, 2'd1);
      tick();
      chk_en = 1'b1;
      chk("rst_ready", W'(pipe_in_ready), W'(1'b1));
      for (int n = 0; n < 4; n++) begin
         for (int i = 0; i < LANES; i++) word_v[32*i +: 32] = 32'(4 * n + i);
         pipe_in_write = 1'b1; pipe_in_data = word_v;
         tick();
      end
      pipe_in_write = 1'b0;
      chk("t1_errors", W'(error_count), W'(0));
      chk("t1_words", W'(word_count), W'(4));
      chk("t1_fev", W'(first_err_valid), W'(0));

      // LFSR seeded from zero fixed pattern; corrupt lane 1 of word 2.
      do_reset(32'd0, 32'd0, 2'd3);
      chk("mdl_lfsr0", exp_word(m, 2'd3, 32'd0), {LANES{32'h0000_0001}});
      pipe_in_write = 1'b1; pipe_in_data = {LANES{32'h0000_0001}};
      tick();
      chk("mdl_lfsr1", exp_word(m, 2'd3, 32'd0), {LANES{32'h0004_2021}});
      pipe_in_data = {LANES{32'h0004_2021}};
      tick();
      exp_v  = exp_word(m, 2'd3, 32'd0);
      word_v = exp_v;
      word_v[63:32] = word_v[63:32] ^ 32'hDEAD_BEEF;
      pipe_in_data = word_v;
      tick();
      pipe_in_write = 1'b0;
      chk("t2_errors", W'(error_count), W'(1));
      chk("t2_index", W'(first_err_index), W'(2));
      chk("t2_expected", first_err_expected, exp_v);
      chk("t2_received", first_err_received, word_v);

      // No drain: fill to the ready threshold and on to overflow.
      do_reset(32'd0, $urandom, 2'd0);
      first_low = 0;
      for (int k = 1; k <= DEPTH; k++) begin
         put(1'b0);
         if (!pipe_in_ready && first_low == 0) first_low = k;
      end
      chk("t3_ready_fall", W'(first_low), W'(DEPTH - BLOCK + 1));
      chk("t3_no_ovf", W'(overflow), W'(0));
      put(1'b0);
      chk("t3_ovf", W'(overflow), W'(1));

      // Drain every cycle while writing every cycle: level stays 0.
      do_reset(32'hFFFF_FFFF, $urandom, 2'd2);
      for (int k = 0; k < 40; k++) put($urandom_range(0, 3) == 0);
      chk("t4_ready_full_drain", W'(pipe_in_ready), W'(1));

      // Single-bit throttle drains one word every 32 cycles.
      do_reset(32'd0, $urandom, 2'd1);
      for (int k = 0; k < DEPTH - BLOCK + 1; k++) put(1'b0);
      throttle_set = 1'b1; throttle_val = 32'h0000_0001;
      tick();
      throttle_set = 1'b0;
      for (int k = 0; k < 32; k++) tick();
      chk("t4_ready_low", W'(pipe_in_ready), W'(0));
      for (int k = 0; k < 32; k++) tick();
      chk("t4_ready_back", W'(pipe_in_ready), W'(1));

      // Saturation of error_count, then clear together with a write.
      pattern = 2'd1;
      preset_err = 1'b1;
      force dut.error_count = 32'hFFFF_FFFD;
      #1;
      release dut.error_count;
      tick();
      preset_err = 1'b0;
      for (int k = 0; k < 4; k++) put(1'b1);
      chk("t5_saturated", W'(error_count), W'(32'hFFFF_FFFF));
      clear_stats = 1'b1;
      put(1'b1);
      clear_stats = 1'b0;
      chk("t5_clr_errors", W'(error_count), W'(0));
      chk("t5_clr_words", W'(word_count), W'(0));
      for (int k = 0; k < 3; k++) put(1'b0);
      chk("t5_gen_kept", W'(error_count), W'(0));
      chk("t5_words", W'(word_count), W'(3));

      // Reset mid-stream at level 500.
      do_reset(32'd0, $urandom, 2'd0);
      for (int k = 0; k < 500; k++) put($urandom_range(0, 7) == 0);
      reset_n = 1'b0;
      tick();
      chk("t6_ready", W'(pipe_in_ready), W'(0));
      chk("t6_errors", W'(error_count), W'(0));
      chk("t6_words", W'(word_count), W'(0));
      chk("t6_fev", W'(first_err_valid), W'(0));
      reset_n = 1'b1;
      tick();
      chk("t6_ready_back", W'(pipe_in_ready), W'(1));

      // Random traffic across all modes and controls.
      for (int c = 0; c < 3000; c++) begin
         reset_n      = ($urandom_range(0, 299) != 0);
         clear_stats  = ($urandom_range(0, 49) == 0);
         throttle_set = ($urandom_range(0, 29) == 0);
         case ($urandom_range(0, 2))
            0:       throttle_val = 32'd0;
            1:       throttle_val = 32'hFFFF_FFFF;
            default: throttle_val = $urandom;
         endcase
         if ($urandom_range(0, 49) == 0) pattern = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 99) == 0) fixed_pattern = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 9) < 7) begin
            put($urandom_range(0, 9) == 0);
         end else begin
            pipe_in_data = {$urandom, $urandom, $urandom, $urandom};
            tick();
         end
      end
      reset_n = 1'b1; clear_stats = 1'b0; throttle_set = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
